// File: rtl/sar_pkg.sv
// Shared types and default sizing for the SAR ADC controller.
// State and phase encodings are used by sar_logic and visible to benches.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } sar_state_e;

    typedef enum logic {
        PH_TRIAL  = 1'b0,
        PH_DECIDE = 1'b1
    } sar_phase_e;

    localparam int NDAC_DEFAULT        = 16;
    localparam int SAMP_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sar_logic.sv
// SAR controller: sample window, then MSB-first binary search; result_valid SampCycles+2*Ndac+1 cycles after start.
// No backpressure: start is only accepted in IDLE/DONE and otherwise dropped; every output is a register.
module sar_logic
    import sar_pkg::*;
#(
    parameter int Ndac       = NDAC_DEFAULT,
    parameter int SampCycles = SAMP_CYCLES_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            comp_out,
    output logic            busy,
    output logic            samp,
    output logic            comp_strobe,
    output logic [Ndac-1:0] dac_bot,
    output logic [Ndac-1:0] dac_bot_d,
    output logic [Ndac-1:0] result,
    output logic            result_valid
);

    localparam int BitW = $clog2(Ndac);
    localparam int CntW = $clog2(SampCycles + 1);

    sar_state_e      r_state;
    sar_phase_e      r_phase;
    logic [BitW-1:0] r_bit;
    logic [CntW-1:0] r_cnt;
    logic [Ndac-1:0] r_dac;
    logic [Ndac-1:0] r_dac_d;
    logic [Ndac-1:0] r_result;
    logic            r_busy;
    logic            r_samp;
    logic            r_strobe;
    logic            r_valid;

    sar_state_e      w_state_nxt;
    sar_phase_e      w_phase_nxt;
    logic [BitW-1:0] w_bit_nxt;
    logic [CntW-1:0] w_cnt_nxt;
    logic [Ndac-1:0] w_dac_nxt;
    logic [Ndac-1:0] w_result_nxt;
    logic [Ndac-1:0] w_bit_mask;
    logic [Ndac-1:0] w_decided;

    assign w_bit_mask = Ndac'(1) << r_bit;

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_bit_nxt    = r_bit;
        w_cnt_nxt    = r_cnt;
        w_dac_nxt    = r_dac;
        w_result_nxt = r_result;
        w_decided    = r_dac;

        case (r_state)
            ST_IDLE: begin
                w_dac_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_SAMPLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SAMPLE: begin
                w_dac_nxt = '0;
                if (r_cnt == CntW'(SampCycles - 1)) begin
                    w_state_nxt = ST_CONVERT;
                    w_phase_nxt = PH_TRIAL;
                    w_bit_nxt   = BitW'(Ndac - 1);
                    w_dac_nxt   = Ndac'(1) << (Ndac - 1);
                end else begin
                    w_cnt_nxt = r_cnt + CntW'(1);
                end
            end
            ST_CONVERT: begin
                if (r_phase == PH_TRIAL) begin
                    w_phase_nxt = PH_DECIDE;
                end else begin
                    // comp_out=1 means the trial code overshot the sampled input
                    w_decided = comp_out ? (r_dac & ~w_bit_mask) : r_dac;
                    if (r_bit == '0) begin
                        w_state_nxt  = ST_DONE;
                        w_dac_nxt    = w_decided;
                        w_result_nxt = w_decided;
                    end else begin
                        w_bit_nxt   = r_bit - BitW'(1);
                        w_phase_nxt = PH_TRIAL;
                        w_dac_nxt   = w_decided | (w_bit_mask >> 1);
                    end
                end
            end
            ST_DONE: begin
                w_dac_nxt = '0;
                if (start) begin
                    w_state_nxt = ST_SAMPLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_dac_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_phase  <= PH_TRIAL;
            r_bit    <= '0;
            r_cnt    <= '0;
            r_dac    <= '0;
            r_dac_d  <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_samp   <= 1'b0;
            r_strobe <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_bit    <= w_bit_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dac    <= w_dac_nxt;
            r_dac_d  <= r_dac;
            r_result <= w_result_nxt;
            // Status flags are decoded from the next state so they line up with it
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_samp   <= (w_state_nxt == ST_SAMPLE);
            r_strobe <= (w_state_nxt == ST_CONVERT) && (w_phase_nxt == PH_TRIAL);
            r_valid  <= (w_state_nxt == ST_DONE);
        end
    end

    assign busy         = r_busy;
    assign samp         = r_samp;
    assign comp_strobe  = r_strobe;
    assign dac_bot      = r_dac;
    assign dac_bot_d    = r_dac_d;
    assign result       = r_result;
    assign result_valid = r_valid;

endmodule

// File: tb/tb_sar_logic.sv
// Scoreboard bench for sar_logic at Ndac=4, SampCycles=2 with an ideal comparator.
module tb_sar_logic;

    localparam int N = 4;
    localparam int S = 2;
    localparam int LAT = S + 2 * N + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         comp_out;
    logic         busy;
    logic         samp;
    logic         comp_strobe;
    logic [N-1:0] dac_bot;
    logic [N-1:0] dac_bot_d;
    logic [N-1:0] result;
    logic         result_valid;

    typedef struct {
        logic [N-1:0]   res;
        logic [4*N-1:0] trials;
        int             vcyc;
    } exp_t;

    exp_t sbq[$];
    int   vin;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   chain = 1'b0;

    sar_logic #(.Ndac(N), .SampCycles(S)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .comp_out     (comp_out),
        .busy         (busy),
        .samp         (samp),
        .comp_strobe  (comp_strobe),
        .dac_bot      (dac_bot),
        .dac_bot_d    (dac_bot_d),
        .result       (result),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [N-1:0] r, input logic [4*N-1:0] t, input int vc);
        exp_t e;
        e.res    = r;
        e.trials = t;
        e.vcyc   = vc;
        sbq.push_back(e);
    endtask

    task automatic convert(input int v, input logic [N-1:0] r, input logic [4*N-1:0] t);
        vin   = v;
        start = 1'b1;
        push_exp(r, t, cyc + LAT);
        tick();
        start = 1'b0;
        repeat (LAT + 3) tick();
    endtask

    // Ideal comparator: decision latched while the strobe is high, held through DECIDE
    initial begin
        comp_out = 1'b0;
        forever begin
            @(negedge clk);
            if (comp_strobe) comp_out = (int'(dac_bot) > vin);
        end
    end

    // Monitor
    initial begin
        logic [N-1:0]   prev_dac;
        logic [4*N-1:0] trials;
        logic           prev_strobe;
        logic           prev_valid;
        logic           last_rst;
        bit             first;
        int             nstrobe;
        exp_t           e;
        prev_dac    = '0;
        trials      = '0;
        prev_strobe = 1'b0;
        prev_valid  = 1'b0;
        last_rst    = 1'b1;
        first       = 1'b1;
        nstrobe     = 0;
        forever begin
            @(negedge clk);
            if (!first && !last_rst) check("dac_bot_d_lag", dac_bot_d, prev_dac);
            if (comp_strobe) begin
                check("strobe_not_back_to_back", prev_strobe, 0);
                check("strobe_in_convert", {busy, samp}, 2'b10);
                trials = {trials[3*N-1:0], dac_bot};
                nstrobe++;
            end
            if (result_valid) begin
                if (sbq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got result %0h with empty scoreboard (cycle %0d)", result, cyc);
                end else begin
                    e = sbq.pop_front();
                    check("result", result, e.res);
                    check("trial_sequence", trials, e.trials);
                    check("valid_cycle", cyc, e.vcyc);
                    check("strobes_per_conv", nstrobe, N);
                end
                trials  = '0;
                nstrobe = 0;
            end
            if (prev_valid) begin
                if (chain) begin
                    check("samp_after_done", samp, 1);
                end else begin
                    check("dac_zero_on_idle", dac_bot, 0);
                    check("busy_low_on_idle", busy, 0);
                end
            end
            if (rst) begin
                trials  = '0;
                nstrobe = 0;
            end
            prev_dac    = dac_bot;
            prev_strobe = comp_strobe;
            prev_valid  = result_valid;
            last_rst    = rst;
            first       = 1'b0;
        end
    end

    // Stimulus
    initial begin
        int c;
        rst   = 1'b1;
        start = 1'b1;
        vin   = 0;
        repeat (3) tick();
        check("rst_outputs", {busy, samp, comp_strobe, result_valid, dac_bot, dac_bot_d, result}, 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) tick();
        check("idle_outputs", {busy, samp, comp_strobe, result_valid, dac_bot, dac_bot_d, result}, 0);

        // Single conversions: nominal and extremes
        convert(10, 4'b1010, 16'h8CAB);
        convert(15, 4'b1111, 16'h8CEF);
        convert(0,  4'b0000, 16'h8421);

        // Back-to-back with start held
        chain = 1'b1;
        vin   = 3;
        start = 1'b1;
        c     = cyc;
        push_exp(4'b0011, 16'h8423, c + LAT);
        push_exp(4'b1100, 16'h8CED, c + 2 * LAT);
        push_exp(4'b0111, 16'h8467, c + 3 * LAT);
        while (cyc < c + LAT) tick();
        vin = 12;
        while (cyc < c + 2 * LAT) tick();
        vin = 7;
        while (cyc < c + 3 * LAT) tick();
        start = 1'b0;
        chain = 1'b0;
        repeat (3) tick();

        // start pulses during SAMPLE and CONVERT are ignored
        vin   = 5;
        start = 1'b1;
        c     = cyc;
        push_exp(4'b0101, 16'h8465, c + LAT);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < c + 5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (LAT + 3) tick();

        // Reset in the third TRIAL cycle aborts the conversion
        vin   = 6;
        start = 1'b1;
        c     = cyc;
        tick();
        start = 1'b0;
        while (cyc < c + S + 5) tick();
        check("third_trial_strobe", comp_strobe, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outputs", {busy, samp, comp_strobe, result_valid, dac_bot, dac_bot_d, result}, 0);
        repeat (LAT) tick();
        convert(9, 4'b1001, 16'h8CA9);

        check("scoreboard_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
